// File: rtl/npc_pkg.sv
// Shared NPC core constants: default register-file geometry and ABI indices.
// No ports; imported by the register file and its scoreboard.
package npc_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_RA   = 1;
  localparam int unsigned REG_SP   = 2;
  localparam int unsigned REG_GP   = 3;
  localparam int unsigned REG_TP   = 4;
  localparam int unsigned REG_T0   = 5;
  localparam int unsigned REG_S0   = 8;
  localparam int unsigned REG_A0   = 10;
  localparam int unsigned REG_A1   = 11;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: alloc sets, write clears, alloc wins on a tie.
// Ports: clk, rst, rd_addr/rd_busy per read port, wr_en/wr_addr, alloc, busy_vec.
module regfile_scoreboard
  import npc_pkg::*;
#(
  parameter  int NREG   = NREG_DEF,
  parameter  int NRD    = 2,
  parameter  int NWR    = 1,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_rd,
  output logic [NREG-1:0]   busy_vec
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;
  logic [NREG-1:0] nxt;

  always_comb begin
    clr = '0;
    set = '0;
    if (!rst) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
          clr[wr_addr[j*AW +: AW]] = 1'b1;
      end
      if (alloc_en && alloc_rd != '0)
        set[alloc_rd] = 1'b1;
    end
    // set is applied last: a new producer supersedes the retiring one
    nxt    = (busy_q & ~clr) | set;
    busy_d = rst ? '0 : nxt;
  end

  always_ff @(posedge clk)
    busy_q <= busy_d;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = rd_addr[i*AW +: AW];
    assign rd_busy[i] = (BYPASS != 0) ? nxt[ra] : busy_q[ra];
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and busy scoreboard.
// Ports: clk, rst, rd_addr/rd_data/rd_busy, wr_en/wr_addr/wr_data, alloc, dbg, busy_vec.
module regfile_mp
  import npc_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD*$clog2(NREG)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]    rd_data,
  output logic [NRD-1:0]         rd_busy,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*$clog2(NREG)-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0]    wr_data,
  input  logic                   alloc_en,
  input  logic [$clog2(NREG)-1:0] alloc_rd,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [XLEN-1:0]        dbg_data,
  output logic [NREG-1:0]        busy_vec
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  logic [AW-1:0]   wa [NWR];
  logic [XLEN-1:0] wd [NWR];
  logic [NWR-1:0]  wv;

  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign wa[j] = wr_addr[j*AW +: AW];
    assign wd[j] = wr_data[j*XLEN +: XLEN];
    // index 0 is hardwired, so writes to it are dropped here
    assign wv[j] = !rst && wr_en[j] && (wa[j] != '0);
  end

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        regs_d[r] = '0;
    end else begin
      // ascending order: highest-index port wins
      for (int j = 0; j < NWR; j++) begin
        if (wv[j])
          regs_d[wa[j]] = wd[j];
      end
    end
  end

  always_ff @(posedge clk)
    regs_q <= regs_d;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] val;
    assign ra = rd_addr[i*AW +: AW];
    always_comb begin
      val = regs_q[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wv[j] && wa[j] == ra)
            val = wd[j];
        end
      end
      if (ra == '0)
        val = '0;
    end
    assign rd_data[i*XLEN +: XLEN] = val;
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

  regfile_scoreboard #(
    .NREG   (NREG),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .alloc_en (alloc_en),
    .alloc_rd (alloc_rd),
    .busy_vec (busy_vec)
  );

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the NPC core, generalising the current single-write, two-read 64-bit GPR array. Adds configurable width, depth and read/write port counts, write-to-read bypass, and a per-register busy scoreboard for hazard detection in the pipelined datapath. It sits between decode (reads, allocation) and write-back (writes), and provides a debug read port for difftest.

## Interface
- XLEN, 64: register width in bits.
- NREG, 32: number of architectural registers; power of two, at least 2. AW = $clog2(NREG) is a localparam.
- NRD, 2: number of read ports.
- NWR, 1: number of write ports, 1 to 4.
- BYPASS, 1: 1 forwards same-cycle write data to the read ports.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NRD*AW  read addresses; port i uses [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data; combinational.
- rd_busy  out  NRD  busy flag of each addressed register; combinational.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- alloc_en  in  1  marks register alloc_rd as having a pending producer.
- alloc_rd  in  AW  destination being allocated.
- dbg_addr  in  AW  debug/difftest read address.
- dbg_data  out  XLEN  debug read data; never bypassed.
- busy_vec  out  NREG  full scoreboard; bit 0 is always 0.

## Operation
- Storage: NREG x XLEN flops. Register 0 reads as 0; writes and allocations to index 0 are ignored.
- Write: on an edge with wr_en[j] set and wr_addr[j] != 0, reg[wr_addr[j]] takes wr_data[j]. If several ports target the same register, the highest-index port wins.
- Read: rd_data[i] is reg[rd_addr[i]]. When BYPASS=1 and some enabled, non-zero write matches rd_addr[i], rd_data[i] returns that write's data instead, with the same highest-index priority. When BYPASS=0, the read returns the old value.
- Scoreboard:
  - busy[r] sets on alloc_en with alloc_rd = r, r != 0.
  - busy[r] clears on any enabled write to r.
  - If alloc and write hit the same r in the same cycle, alloc wins and busy stays 1, because the new producer supersedes the old one.
- rd_busy[i] is busy[rd_addr[i]] after bypass: it reads 0 if a same-cycle write clears that register and no same-cycle alloc sets it. With BYPASS=0 it reflects the registered value only.
- All control inputs are ignored while rst is high.

## Timing
- Reset: on the first edge with rst high, all registers become 0 and all busy bits become 0. After that edge, rd_data, dbg_data, rd_busy and busy_vec all read 0. Before the first reset they are undefined.
- Reset asserted mid-operation takes effect on that edge, overriding any concurrent write or alloc.
- Write latency: 1 edge to storage and dbg_data. With BYPASS=1 the value is visible on rd_data in the same cycle.
- Scoreboard latency: busy_vec updates 1 edge after alloc or write.
- No handshakes; every port is valid every cycle.

## Structure
- Shared package npc_pkg holds default XLEN/NREG constants and the ABI register-index localparams (RA=1, SP=2, A0=10, ...).
- One sub-module, regfile_scoreboard: busy flops, alloc/clear priority logic and rd_busy lookup. Data storage and bypass muxes stay in regfile_mp.
- Unpacking and priority resolution are generate loops over NRD and NWR. The current fixed-key mux instances are not used.

## Test plan
- Reset then write 0xDEAD_BEEF to reg 5: the next cycle, rd_addr=5 returns 0xDEAD_BEEF and dbg_addr=5 matches.
- Write 0x1234 to reg 0, then read reg 0: returns 0, and busy_vec[0] stays 0 after alloc_rd=0.
- BYPASS=1, write 0xAA to reg 7 while reading reg 7 in the same cycle: rd_data is 0xAA. With BYPASS=0 it is the old value, 0.
- NWR=2, both ports write reg 3 (0x11 on port 0, 0x22 on port 1): reg 3 becomes 0x22.
- Alloc reg 9: busy_vec[9]=1 on the next cycle. Write reg 9 with a simultaneous alloc of reg 9: busy stays 1. A later write-only to reg 9: busy clears.
- Populate regs 1–31 and set busy bits, then assert rst for one cycle with a concurrent write: every register reads 0 and busy_vec is 0.
